// File: rtl/gol_pkg.sv
// Shared grid constants, engine-operation encoding and scheduler state type
// for the Game-of-Life scheduler slice.
package gol_pkg;

    localparam int MAX_X = 64;
    localparam int MAX_Y = 48;

    typedef enum logic [1:0] {
        OP_NONE  = 2'd0,
        OP_GEN   = 2'd1,
        OP_STAMP = 2'd2,
        OP_CLEAR = 2'd3
    } eng_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_RUN,
        ST_WAIT_VB,
        ST_SWAP
    } sched_state_e;

    // Saturate a cursor coordinate to the last valid cell index.
    function automatic logic [7:0] clamp_coord(input logic [7:0] v, input int lim);
        return (int'(v) > lim - 1) ? 8'(lim - 1) : v;
    endfunction

endpackage

// File: rtl/gol_req_latch.sv
// One-deep request latch: optional rising-edge detect on a level input,
// a pending flag consumed by the scheduler, and a sticky overrun flag.
module gol_req_latch #(
    parameter bit LEVEL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_qual,
    input  logic i_aux_set,
    input  logic i_take,
    input  logic i_flush,
    output logic o_pend,
    output logic o_hit,
    output logic o_overrun
);
    logic r_req_d;
    logic r_pend;
    logic r_overrun;
    logic w_hit;

    assign w_hit = (LEVEL ? (i_req & ~r_req_d) : i_req) & i_qual;

    // NOTE: non-blocking assignments here so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_req_d   <= 1'b1;  // a level held through reset must first drop before it counts
            r_pend    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_req_d <= i_req;
            if (w_hit && r_pend && !i_take) r_overrun <= 1'b1;
            if (i_take || i_flush) r_pend <= 1'b0;
            if (w_hit || i_aux_set) r_pend <= 1'b1;
        end
    end

    assign o_pend    = r_pend;
    assign o_hit     = w_hit;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/gol_scheduler.sv
// Serialises generation/stamp/clear requests into one grid-engine op at a time
// and swaps the displayed buffer in vblank. Define GOL_SCHED_STEP_EN to enable single-step while frozen.
module gol_scheduler
    import gol_pkg::*;
#(
    parameter int ENG_TIMEOUT = 8192
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_gen_tick,
    input  logic        i_freeze,
    input  logic        i_step_req,
    input  logic        i_draw_req,
    input  logic        i_clear_req,
    input  logic [7:0]  i_cursor_x,
    input  logic [7:0]  i_cursor_y,
    input  logic [3:0]  i_pattern_idx,
    input  logic        i_vblank,
    input  logic        i_eng_done,
    output logic        o_eng_start,
    output logic [1:0]  o_eng_op,
    output logic [7:0]  o_op_x,
    output logic [7:0]  o_op_y,
    output logic [3:0]  o_op_pattern,
    output logic        o_front_sel,
    output logic        o_busy,
    output logic [15:0] o_gen_count,
    output logic        o_overrun,
    output logic        o_eng_timeout
);
    localparam int CNT_W = $clog2(ENG_TIMEOUT + 1);

    sched_state_e     r_state;
    eng_op_e          r_eng_op;
    logic             r_eng_start, r_front_sel, r_busy, r_eng_timeout, r_freeze_d;
    logic [7:0]       r_op_x, r_op_y, r_stamp_x, r_stamp_y;
    logic [3:0]       r_op_pattern, r_stamp_pat;
    logic [15:0]      r_gen_count;
    logic [CNT_W-1:0] r_cnt;

    logic w_gen_pend, w_stamp_pend, w_clear_pend, w_stamp_hit, w_gen_ovr;
    logic w_take_gen, w_take_stamp, w_take_clear, w_freeze_rise, w_step_set;
    logic w_unused_gen_hit, w_unused_clear_hit, w_unused_stamp_ovr, w_unused_clear_ovr;

    assign w_freeze_rise = i_freeze & ~r_freeze_d;
    assign w_take_clear  = (r_state == ST_IDLE) & w_clear_pend;
    assign w_take_stamp  = (r_state == ST_IDLE) & w_stamp_pend & ~w_clear_pend;
    assign w_take_gen    = (r_state == ST_IDLE) & w_gen_pend & ~w_clear_pend & ~w_stamp_pend;

`ifdef GOL_SCHED_STEP_EN
    logic r_step_d;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_step_d <= 1'b1;
        else       r_step_d <= i_step_req;
    end
    assign w_step_set = i_step_req & ~r_step_d & i_freeze;
`else
    logic w_unused_step;
    assign w_unused_step = i_step_req;
    assign w_step_set    = 1'b0;
`endif

    gol_req_latch #(.LEVEL(1'b0)) u_gen_latch (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_gen_tick), .i_qual(~i_freeze),
        .i_aux_set(w_step_set), .i_take(w_take_gen), .i_flush(w_freeze_rise),
        .o_pend(w_gen_pend), .o_hit(w_unused_gen_hit), .o_overrun(w_gen_ovr)
    );

    gol_req_latch #(.LEVEL(1'b1)) u_stamp_latch (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_draw_req), .i_qual(1'b1),
        .i_aux_set(1'b0), .i_take(w_take_stamp), .i_flush(1'b0),
        .o_pend(w_stamp_pend), .o_hit(w_stamp_hit), .o_overrun(w_unused_stamp_ovr)
    );

    gol_req_latch #(.LEVEL(1'b1)) u_clear_latch (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_clear_req), .i_qual(1'b1),
        .i_aux_set(1'b0), .i_take(w_take_clear), .i_flush(1'b0),
        .o_pend(w_clear_pend), .o_hit(w_unused_clear_hit), .o_overrun(w_unused_clear_ovr)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_eng_op      <= OP_NONE;
            r_eng_start   <= 1'b0;
            r_front_sel   <= 1'b0;
            r_busy        <= 1'b0;
            r_eng_timeout <= 1'b0;
            r_freeze_d    <= 1'b1;
            r_op_x        <= '0;
            r_op_y        <= '0;
            r_op_pattern  <= '0;
            r_stamp_x     <= '0;
            r_stamp_y     <= '0;
            r_stamp_pat   <= '0;
            r_gen_count   <= '0;
            r_cnt         <= '0;
        end else begin
            r_freeze_d <= i_freeze;
            // A later draw edge simply overwrites an unserved stamp.
            if (w_stamp_hit) begin
                r_stamp_x   <= clamp_coord(i_cursor_x, MAX_X);
                r_stamp_y   <= clamp_coord(i_cursor_y, MAX_Y);
                r_stamp_pat <= i_pattern_idx;
            end
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_take_clear || w_take_stamp || w_take_gen) begin
                        r_state      <= ST_ISSUE;
                        r_busy       <= 1'b1;
                        r_eng_start  <= 1'b1;
                        r_op_x       <= '0;
                        r_op_y       <= '0;
                        r_op_pattern <= '0;
                        if (w_take_clear) begin
                            r_eng_op <= OP_CLEAR;
                        end else if (w_take_stamp) begin
                            r_eng_op     <= OP_STAMP;
                            r_op_x       <= r_stamp_x;
                            r_op_y       <= r_stamp_y;
                            r_op_pattern <= r_stamp_pat;
                        end else begin
                            r_eng_op <= OP_GEN;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_eng_start <= 1'b0;
                    r_cnt       <= r_cnt + 1'b1;
                    r_state     <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_eng_done) begin
                        r_state <= ST_WAIT_VB;
                    end else if (r_cnt == CNT_W'(ENG_TIMEOUT)) begin
                        r_eng_timeout <= 1'b1;
                        r_eng_op      <= OP_NONE;
                        r_busy        <= 1'b0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_WAIT_VB: begin
                    if (i_vblank) r_state <= ST_SWAP;
                end
                ST_SWAP: begin
                    r_front_sel <= ~r_front_sel;
                    if (r_eng_op == OP_GEN) r_gen_count <= r_gen_count + 16'd1;
                    r_eng_op <= OP_NONE;
                    r_busy   <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_eng_start   = r_eng_start;
    assign o_eng_op      = r_eng_op;
    assign o_op_x        = r_op_x;
    assign o_op_y        = r_op_y;
    assign o_op_pattern  = r_op_pattern;
    assign o_front_sel   = r_front_sel;
    assign o_busy        = r_busy;
    assign o_gen_count   = r_gen_count;
    assign o_overrun     = w_gen_ovr;
    assign o_eng_timeout = r_eng_timeout;

endmodule

// File: doc/gol_scheduler.md
# gol_scheduler

Sequencer that owns access to the Game-of-Life grid engine and its double-buffered state. It accepts generation ticks, pattern-stamp requests from the keypad/cursor path and clear requests, serialises them into one engine operation at a time, and swaps the displayed buffer only during vertical blanking. It sits between the input blocks (cursor, keypad, game timer) and the grid engine/VGA display, replacing free-running divided clocks with one clock plus handshakes.

## Interface
- MAX_X, 64, grid width in cells
- MAX_Y, 48, grid height in cells
- ENG_TIMEOUT, 8192, max cycles from eng_start to eng_done before abort
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- gen_tick  in  1  one-cycle pulse from game-rate timer
- freeze  in  1  level; suppresses automatic generations
- step_req  in  1  level; single generation while frozen (rising edge)
- draw_req  in  1  level from keypad (rising edge)
- clear_req  in  1  level (rising edge)
- cursor_x  in  8  stamp anchor column
- cursor_y  in  8  stamp anchor row
- pattern_idx  in  4  pattern to stamp
- vblank  in  1  level from display timing
- eng_done  in  1  one-cycle pulse, engine finished current op
- eng_start  out  1  one-cycle pulse, begin op
- eng_op  out  2  0 NONE, 1 GEN, 2 STAMP, 3 CLEAR; held until eng_done
- op_x, op_y  out  8 each  clamped anchor, held with eng_op
- op_pattern  out  4  latched pattern_idx
- front_sel  out  1  buffer currently displayed; engine reads front, writes back
- busy  out  1  high in any state other than IDLE
- gen_count  out  16  completed generations, wraps at 0xFFFF to 0
- overrun  out  1  sticky: gen_tick arrived while GEN already pending
- eng_timeout  out  1  sticky: engine timeout occurred

## Operation
- Request latches (one-deep each): gen_pend, stamp_pend, clear_pend. draw_req/clear_req/step_req rising-edge detected internally; gen_tick taken as pulse.
- gen_tick sets gen_pend only when freeze=0; gen_tick with gen_pend already set: dropped, overrun<=1. freeze rising clears gen_pend.
- Stamp latch captures cursor_x/cursor_y/pattern_idx in the edge cycle; x clamped to MAX_X-1, y to MAX_Y-1. A second draw edge while stamp_pend overwrites the captured values.
- States: IDLE, ISSUE, RUN, WAIT_VB, SWAP.
- IDLE: if any pending, select by priority CLEAR > STAMP > GEN, clear that latch, load eng_op/op_*, go ISSUE.
- ISSUE (1 cycle): eng_start=1, go RUN.
- RUN: on eng_done go WAIT_VB; counter reaching ENG_TIMEOUT: eng_timeout<=1, eng_op<=NONE, go IDLE, no swap.
- WAIT_VB: when vblank=1 go SWAP (same-cycle vblank acceptable).
- SWAP (1 cycle): front_sel toggles; gen_count+1 if op was GEN; eng_op<=NONE; go IDLE.
- Requests arriving in any non-IDLE state are latched, served after return to IDLE.

## Timing
- Reset values: eng_start 0, eng_op 0, op_x/op_y/op_pattern 0, front_sel 0, busy 0, gen_count 0, overrun 0, eng_timeout 0; all latches and edge detectors cleared (level inputs high at reset release do not generate an edge).
- Request latched cycle N (IDLE) -> selected N+1 -> eng_start high N+2.
- eng_done coincident with eng_start ignored; engine must respond no earlier than cycle after eng_start.
- eng_done with vblank already high: SWAP 2 cycles later, front_sel visible 3 cycles after eng_done.
- Back-to-back: minimum 2 idle-to-issue cycles between consecutive ops.
- Reset mid-operation: immediate return to IDLE, pending discarded, front_sel back to 0; engine shares rst.

## Configuration
- GOL_SCHED_STEP_EN defined: step_req rising edge while freeze=1 sets gen_pend (ignored if freeze=0).
- Undefined: step_req ignored; port present but unused; frozen grid changes only by stamp/clear.

## Structure
- Shared package gol_pkg: MAX_X/MAX_Y constants, eng_op encoding (OP_NONE/GEN/STAMP/CLEAR), scheduler state enum.
- One sub-module: gol_req_latch (edge detect + one-deep pending flag + overrun), instantiated per request source.

## Test plan
- gen_tick, freeze=0, engine done after 10 cycles, vblank high -> eng_op=1, eng_start 2 cycles after tick, front_sel 0->1, gen_count=1.
- draw_req rise with cursor (70,50), pattern 5, concurrent gen_tick -> STAMP issued first with op_x=63, op_y=47, op_pattern=5; then GEN.
- Two gen_ticks during RUN -> overrun=1, exactly one further GEN executed.
- eng_done with vblank low 500 cycles -> front_sel unchanged until vblank rises, then toggles once.
- Engine never returns done -> after 8192 cycles eng_timeout=1, IDLE, front_sel unchanged; with GOL_SCHED_STEP_EN, freeze=1 + step_req edge -> one GEN, gen_count+1; without macro none.
- rst asserted in RUN -> next cycle all outputs at reset values, pending clear.
